ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares the single-port 64K x 32 on-chip RAM between NUM_REQ masters, for example the Nios II data master and the accelerator's matrix read and write engines.
- Sits between those masters and the RAM's slave port.
- Issues one RAM access per cycle, returns read data with fixed 1-cycle latency, and routes each read response to the requester that issued it.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 16, word address width
- DATA_W, 32, data width; BE_W = DATA_W/8
- MAX_LOCK, 16, maximum consecutive locked grants (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-requester access request
- wr  in  NUM_REQ  1 = write, 0 = read, per requester
- addr  in  NUM_REQ*ADDR_W  packed word addresses; requester i occupies [i*ADDR_W +: ADDR_W]
- be  in  NUM_REQ*BE_W  packed byte enables
- wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  one-hot grant; the command is accepted this cycle
- rvalid  out  NUM_REQ  one-hot read-data-valid
- rdata  out  DATA_W  read data, shared by all requesters and qualified by rvalid
- ram_chipselect  out  1  RAM chipselect
- ram_write  out  1  RAM write strobe
- ram_address  out  ADDR_W  RAM address
- ram_byteenable  out  BE_W  RAM byte enables
- ram_writedata  out  DATA_W  RAM write data
- ram_readdata  in  DATA_W  RAM read data (unregistered RAM output)

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - All state resets when reset_n is low at a rising edge.
- Reset values:
  - Round-robin pointer = 0, so requester 0 has highest priority.
  - rvalid = 0.
  - lock counter = 0.
  - gnt = 0 and ram_chipselect = 0 while reset_n is low.
- Arbitration (combinational, same cycle):
  - The winner is the first requester with req high, searching upward from the pointer and wrapping modulo NUM_REQ.
  - gnt[winner] = 1; every other gnt is 0.
  - A requester holds req, wr, addr, be and wdata stable until it sees gnt (waitrequest = req & ~gnt).
- RAM drive:
  - When a winner exists: ram_chipselect = 1, ram_write = wr[winner], and address, byte enables and write data are muxed from the winner.
  - When no requester is asserting req: chipselect, write, address, byteenable and writedata are all driven 0.
- Pointer update:
  - On a grant, the pointer moves to winner+1 mod NUM_REQ.
  - With no grant, the pointer holds.
- Writes:
  - Complete in the grant cycle.
  - No response is returned.
- Reads:
  - The RAM samples the address at the grant edge; data appears on ram_readdata in the next cycle.
  - rvalid is a register: rvalid[i] = 1 in the cycle after a read grant to i.
  - rdata = ram_readdata combinationally.
  - No response FIFO is needed, since latency is fixed at 1.
- Throughput:
  - One access per cycle, with back-to-back grants to different requesters.
  - A requester that asserts req every cycle while others are active is served at least once every NUM_REQ cycles.
- Single requester: granted every cycle, at full rate.
- Simultaneous events:
  - A read response for one requester and a new grant to another occur in the same cycle without conflict.
- Reset mid-operation:
  - A read granted in the cycle before reset_n falls produces no rvalid.
  - The pointer returns to 0.
- byteenable = 0 on a write is passed through unchanged; the RAM performs no byte update.

Optional Feature:
- Macro: RAM_ARB_LOCK_EN.
- With the macro defined:
  - An extra input lock [NUM_REQ] is present.
  - If the current owner holds both req and lock high, it keeps the grant on following cycles regardless of other requests and the pointer is frozen.
  - Ownership is released when lock or req falls, or after MAX_LOCK consecutive locked grants.
  - On a forced release, the next cycle arbitrates normally from owner+1.
  - The lock counter resets on release and on reset.
- Without the macro: the port is absent and arbitration is pure round-robin.

Decomposition:
- Package ram_arb_pkg:
  - ADDR_W, DATA_W and BE_W constants.
  - NUM_REQ default.
  - Requester-index typedef (width $clog2(NUM_REQ)).
  - Helper for one-hot-to-index conversion.
- Sub-module rr_arbiter:
  - Parameterised round-robin priority pick plus pointer register.
  - Outputs a one-hot grant and the winner index.
  - Instantiated once; the top level holds the muxes, rvalid pipeline and lock logic.

Test Plan:
- Reset: hold reset_n low 3 cycles with req = 3'b111 -> gnt = 0, ram_chipselect = 0, rvalid = 0; first cycle after release grants requester 0.
- Read latency: preload address 0x0010 = 0xDEADBEEF; req[1] read 0x0010 -> gnt[1] in the request cycle; the next cycle gives rvalid = 3'b010 and rdata = 0xDEADBEEF.
- Fairness: req = 3'b111 held for 9 cycles -> grant order 0,1,2,0,1,2,0,1,2, with 3 grants each.
- Byte write: req[2] writes 0x12345678 with be = 4'b0011 to 0x0020 (previously 0xFFFFFFFF); read back -> 0xFFFF5678.
- Reset mid-read: grant a read to requester 0, drop reset_n on the next edge -> rvalid stays 0.
- Lock (RAM_ARB_LOCK_EN, MAX_LOCK = 4): requester 1 holds lock, req = 3'b111 -> gnt[1] for 4 cycles, then gnt[2].

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared constants, the requester-index type and a one-hot to
//               index helper for the on-chip RAM port arbiter.
//               Contents: RAM_ADDR_W, RAM_DATA_W, RAM_BE_W, NUM_REQ_DEF,
//               MAX_REQ, req_idx_t, onehot_to_idx().
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

   localparam int RAM_ADDR_W  = 16;             // 64K words
   localparam int RAM_DATA_W  = 32;
   localparam int RAM_BE_W    = RAM_DATA_W / 8;
   localparam int NUM_REQ_DEF = 3;              // Nios II data + matrix rd + matrix wr
   localparam int MAX_REQ     = 8;              // upper bound on requesters
   localparam int MAX_IDX_W   = $clog2(MAX_REQ);

   typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_idx_t;

   // Index of the highest set bit of a one-hot vector; 0 when no bit is set.
   function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = MAX_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin priority pick with its own pointer register.
//               The search starts at the pointer and wraps modulo N; after a
//               grant the pointer moves one past the winner.
// Ports       : clk      - clock
//               reset_n  - synchronous active-low reset (pointer -> 0)
//               req      - request vector
//               hold     - freeze the pointer this cycle
//               gnt      - one-hot grant (all zero when no request)
//               winner   - index of the granted requester
//               any      - a grant was issued
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter  int N     = 3,
   localparam int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N-1:0]     req,
   input  logic             hold,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] winner,
   output logic             any
);

   logic [IDX_W-1:0] ptr;
   // One extra bit so ptr+k can exceed N-1 before the wrap subtraction.
   logic [IDX_W:0]   cand;

   always_comb begin
      gnt    = '0;
      winner = '0;
      any    = 1'b0;
      cand   = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
         if (!any && req[cand[IDX_W-1:0]]) begin
            any    = 1'b1;
            winner = cand[IDX_W-1:0];
         end
      end
      if (any) gnt[winner] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (any && !hold) begin
         ptr <= (winner == IDX_W'(N-1)) ? '0 : winner + IDX_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Shares one single-port 64K x 32 RAM between NUM_REQ masters.
//               One access per cycle, round-robin fair; read data returns a
//               fixed one cycle after the grant, tagged by a one-hot rvalid.
//               Optional macro RAM_ARB_LOCK_EN adds a per-requester lock input
//               that lets the current owner keep the port for up to MAX_LOCK
//               consecutive grants.
// Ports       : clk, reset_n           - clock, synchronous active-low reset
//               req, wr, addr, be, wdata - packed per-requester command
//               lock                     - (RAM_ARB_LOCK_EN only) hold request
//               gnt                      - one-hot command accept
//               rvalid, rdata            - read response
//               ram_*                    - RAM slave port
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter  int NUM_REQ  = NUM_REQ_DEF,
   parameter  int ADDR_W   = RAM_ADDR_W,
   parameter  int DATA_W   = RAM_DATA_W,
   parameter  int MAX_LOCK = 16,
   localparam int BE_W     = DATA_W / 8,
   localparam int IDX_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
`ifdef RAM_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        lock,
`endif
   input  logic [NUM_REQ-1:0]        wr,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   input  logic [NUM_REQ*BE_W-1:0]   be,
   input  logic [NUM_REQ*DATA_W-1:0] wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic                      ram_chipselect,
   output logic                      ram_write,
   output logic [ADDR_W-1:0]         ram_address,
   output logic [BE_W-1:0]           ram_byteenable,
   output logic [DATA_W-1:0]         ram_writedata,
   input  logic [DATA_W-1:0]         ram_readdata
);

   // Requests are masked during reset so no grant or RAM access escapes.
   logic [NUM_REQ-1:0] req_act;
   logic [NUM_REQ-1:0] arb_gnt;
   logic [IDX_W-1:0]   arb_winner;
   logic               arb_any;
   logic               arb_hold;
   logic [NUM_REQ-1:0] gnt_int;
   logic [IDX_W-1:0]   sel;
   logic               sel_any;

   assign req_act = req & {NUM_REQ{reset_n}};

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_rr (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req_act),
      .hold    (arb_hold),
      .gnt     (arb_gnt),
      .winner  (arb_winner),
      .any     (arb_any)
   );

`ifdef RAM_ARB_LOCK_EN
   localparam int LCNT_W = $clog2(MAX_LOCK + 1);

   logic              owned;
   logic [IDX_W-1:0]  owner;
   logic [LCNT_W-1:0] lock_cnt;
   logic              lock_keep;

   // lock_cnt counts locked grants already given to the owner, including
   // the normal grant that started ownership.
   assign lock_keep = owned && req_act[owner] && lock[owner] &&
                      (lock_cnt < LCNT_W'(MAX_LOCK));
   // The pointer already sits at owner+1 from the capturing grant, so
   // freezing it makes the post-release arbitration start from owner+1.
   assign arb_hold  = lock_keep;

   always_comb begin
      gnt_int = arb_gnt;
      sel     = arb_winner;
      sel_any = arb_any;
      if (lock_keep) begin
         gnt_int        = '0;
         gnt_int[owner] = 1'b1;
         sel            = owner;
         sel_any        = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         owned    <= 1'b0;
         owner    <= '0;
         lock_cnt <= '0;
      end else if (lock_keep) begin
         lock_cnt <= lock_cnt + LCNT_W'(1);
      end else if (arb_any && lock[arb_winner]) begin
         owned    <= 1'b1;
         owner    <= arb_winner;
         lock_cnt <= LCNT_W'(1);
      end else begin
         owned    <= 1'b0;
         lock_cnt <= '0;
      end
   end
`else
   assign arb_hold = 1'b0;
   assign gnt_int  = arb_gnt;
   assign sel      = arb_winner;
   assign sel_any  = arb_any;
`endif

   assign gnt = gnt_int;

   // RAM command mux; every field is forced to zero when idle.
   always_comb begin
      ram_chipselect = sel_any;
      ram_write      = 1'b0;
      ram_address    = '0;
      ram_byteenable = '0;
      ram_writedata  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel_any && (sel == IDX_W'(i))) begin
            ram_write      = wr[i];
            ram_address    = addr[i*ADDR_W +: ADDR_W];
            ram_byteenable = be[i*BE_W +: BE_W];
            ram_writedata  = wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Fixed one-cycle read latency: the response tag is simply the read
   // grant delayed by one register stage.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rvalid <= '0;
      end else begin
         rvalid <= gnt_int & ~wr;
      end
   end

   assign rdata = ram_readdata;

endmodule
`default_nettype wire
